// File: rtl/joybus_poll_sched.sv
// JoyBus poll sequencer: TX command, edge-armed RX of one 32-bit frame, latch.
// Periodic and forced polls with edge/RX timeouts, auto-retry and link tracking.
module joybus_poll_sched #(
    parameter int unsigned POLL_PERIOD  = 416667,
    parameter int unsigned EDGE_TIMEOUT = 2500,
    parameter int unsigned RX_TIMEOUT   = 5000,
    parameter int unsigned GAP_CYC      = 50,
    parameter int unsigned MAX_RETRY    = 3,
    parameter logic [23:0] POLL_CMD     = 24'h400300
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        force_poll,
    input  logic        jb_line,
    output logic        tx_start,
    output logic [23:0] tx_cmd,
    input  logic        tx_done,
    output logic        rx_start,
    input  logic        rx_done,
    input  logic [31:0] rx_data,
    output logic [31:0] cntlr_data,
    output logic        cntlr_valid,
    output logic        connected,
    output logic        timeout_pulse,
    output logic        busy
);
    localparam int unsigned   PW         = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [PW-1:0] PER_LAST   = PW'(POLL_PERIOD - 1);
    localparam logic [15:0]   EDGE_LAST  = 16'(EDGE_TIMEOUT - 1);
    localparam logic [15:0]   RX_LAST    = 16'(RX_TIMEOUT - 1);
    localparam logic [15:0]   GAP_LAST   = 16'(GAP_CYC - 1);
    localparam logic [2:0]    RETRY_LAST = 3'(MAX_RETRY - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SEND, ST_EDGE, ST_RECV, ST_OK, ST_FAIL, ST_GAP
    } state_t;

    state_t        state;
    logic          jb_sync_p0, jb_sync_p1, jb_hist_p2;
    logic          fall;
    logic [PW-1:0] per_cnt;
    logic          per_wrap;
    logic          pending;
    logic          fail_now;
    logic [15:0]   timer;
    logic [2:0]    retry_cnt;

    assign tx_cmd = POLL_CMD;

    // sync stage: jb_line -> p0 -> p1, p2 holds the previous synchronized level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            jb_sync_p0 <= 1'b1;
            jb_sync_p1 <= 1'b1;
            jb_hist_p2 <= 1'b1;
        end else begin
            jb_sync_p0 <= jb_line;
            jb_sync_p1 <= jb_sync_p0;
            jb_hist_p2 <= jb_sync_p1;
        end
    end

    assign fall     = jb_hist_p2 & ~jb_sync_p1;
    assign per_wrap = enable && (per_cnt == PER_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            per_cnt <= '0;
        end else if (per_wrap) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    // A response edge or rx_done arriving together with timer expiry wins.
    always_comb begin
        fail_now = 1'b0;
        if (state == ST_EDGE) begin
            fail_now = !fall && (timer == EDGE_LAST);
        end else if (state == ST_RECV) begin
            fail_now = !rx_done && (timer == RX_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            tx_start      <= 1'b0;
            rx_start      <= 1'b0;
            cntlr_valid   <= 1'b0;
            timeout_pulse <= 1'b0;
            cntlr_data    <= '0;
            connected     <= 1'b0;
            busy          <= 1'b0;
            pending       <= 1'b0;
            retry_cnt     <= '0;
            timer         <= '0;
        end else begin
            tx_start      <= 1'b0;
            rx_start      <= 1'b0;
            cntlr_valid   <= 1'b0;
            timeout_pulse <= 1'b0;
            if (timer != 16'hFFFF) begin
                timer <= timer + 16'd1;
            end

            case (state)
                ST_IDLE: if (pending) begin
                    state    <= ST_SEND;
                    tx_start <= 1'b1;
                    busy     <= 1'b1;
                    pending  <= 1'b0;
                    timer    <= '0;
                end
                ST_SEND: if (tx_done) begin
                    state <= ST_EDGE;
                    timer <= '0;
                end
                ST_EDGE: if (fall) begin
                    state    <= ST_RECV;
                    rx_start <= 1'b1;
                    timer    <= '0;
                end
                ST_RECV: if (rx_done) begin
                    state       <= ST_OK;
                    cntlr_data  <= rx_data;
                    cntlr_valid <= 1'b1;
                    connected   <= 1'b1;
                    retry_cnt   <= '0;
                    timer       <= '0;
                end
                ST_OK, ST_FAIL: begin
                    state <= ST_GAP;
                    timer <= '0;
                end
                ST_GAP: if (timer == GAP_LAST) begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    timer <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (fail_now) begin
                state         <= ST_FAIL;
                timeout_pulse <= 1'b1;
                timer         <= '0;
                if (retry_cnt == RETRY_LAST) begin
                    connected <= 1'b0;
                    retry_cnt <= '0;
                end else begin
                    retry_cnt <= retry_cnt + 3'd1;
                    pending   <= 1'b1;
                end
            end

            // New requests are never lost, even in the cycle IDLE is left.
            if (force_poll || per_wrap) begin
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_joybus_poll_sched.sv
// Scoreboard bench for joybus_poll_sched: driver predicts pulse timing from the
// transaction rules and queues expected events; a monitor pops and compares them.
module tb_joybus_poll_sched;
    localparam int P   = 100;
    localparam int ET  = 40;
    localparam int RT  = 60;
    localparam int GAP = 8;
    localparam int MR  = 3;
    localparam logic [23:0] CMD = 24'h400300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        force_poll = 1'b0;
    logic        jb_line = 1'b1;
    logic        tx_done = 1'b0;
    logic        rx_done = 1'b0;
    logic [31:0] rx_data = '0;
    logic        tx_start, rx_start, cntlr_valid, connected, timeout_pulse, busy;
    logic [23:0] tx_cmd;
    logic [31:0] cntlr_data;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int          kind;   // 0 tx_start, 1 rx_start, 2 cntlr_valid, 3 timeout_pulse
        int          at;
        logic [31:0] data;
        logic        conn;
    } ev_t;
    ev_t exp_q[$];

    // reference model state
    int          rc = 0;
    logic        m_conn = 1'b0;
    logic [31:0] m_data = '0;

    joybus_poll_sched #(
        .POLL_PERIOD(P), .EDGE_TIMEOUT(ET), .RX_TIMEOUT(RT),
        .GAP_CYC(GAP), .MAX_RETRY(MR), .POLL_CMD(CMD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .force_poll(force_poll),
        .jb_line(jb_line), .tx_start(tx_start), .tx_cmd(tx_cmd), .tx_done(tx_done),
        .rx_start(rx_start), .rx_done(rx_done), .rx_data(rx_data),
        .cntlr_data(cntlr_data), .cntlr_valid(cntlr_valid), .connected(connected),
        .timeout_pulse(timeout_pulse), .busy(busy)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int at, input logic [31:0] d, input logic c);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        e.data = d;
        e.conn = c;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [31:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: kind=%0d at cyc %0d, expected none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.at != cyc || e.data != d || e.conn != connected) begin
                errors++;
                $display("FAIL event: got kind=%0d cyc=%0d data=%h conn=%0b, expected kind=%0d cyc=%0d data=%h conn=%0b",
                         kind, cyc, d, connected, e.kind, e.at, e.data, e.conn);
            end
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            if (tx_start)      observe(0, {8'h00, tx_cmd});
            if (rx_start)      observe(1, cntlr_data);
            if (cntlr_valid)   observe(2, cntlr_data);
            if (timeout_pulse) observe(3, cntlr_data);
        end
    end

    task automatic at_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // kind: 0 success, 1 no response edge, 2 edge but no rx_done, 3 edge only during SEND
    task automatic run_txn(input int s, input int kind, input bit short_mode, input bit allow_fp,
                           output int x_end, output bit pend);
        int d, m, off, k, r, f;
        int t_tx, t_jl, t_jh, t_rx, t_fp, last;
        logic [31:0] data;
        data = $urandom();
        t_jl = -1; t_jh = -1; t_rx = -1; t_fp = -1; r = 0; k = 0;
        expect_ev(0, s, {8'h00, CMD}, m_conn);
        d = (kind == 3) ? int'($urandom_range(4, 8)) : int'($urandom_range(0, short_mode ? 3 : 6));
        t_tx = s + d;
        m = t_tx + 1;
        if (kind == 0 || kind == 2) begin
            case ($urandom_range(0, 3))
                0:       off = 0;
                1:       off = ET - 2;
                default: off = int'($urandom_range(0, short_mode ? 10 : ET - 2));
            endcase
            k = m - 1 + off;
            r = k + 3;
            t_jl = k;
            expect_ev(1, r, m_data, m_conn);
        end
        if (kind == 0) begin
            if (short_mode) f = int'($urandom_range(0, 20));
            else f = ($urandom_range(0, 3) == 0) ? RT - 2 : int'($urandom_range(0, RT - 2));
            t_rx = r + f;
            t_jh = t_rx;
            if (allow_fp && $urandom_range(0, 2) == 0) t_fp = int'($urandom_range(r, t_rx));
            m_data = data;
            m_conn = 1'b1;
            rc = 0;
            x_end = t_rx + 1;
            expect_ev(2, x_end, data, 1'b1);
            pend = (t_fp >= 0);
        end else begin
            if (kind == 2) begin
                x_end = r + RT;
                t_jh = k + 8;
            end else begin
                x_end = m + ET;
                if (kind == 3) begin
                    t_jl = s;
                    t_jh = s + 2;
                end
            end
            rc++;
            if (rc == MR) begin
                rc = 0;
                m_conn = 1'b0;
                pend = 1'b0;
            end else begin
                pend = 1'b1;
            end
            expect_ev(3, x_end, m_data, m_conn);
        end
        last = (t_jh > t_tx) ? t_jh : t_tx;
        for (int t = s; t <= last; t++) begin
            at_cyc(t);
            tx_done    = (t == t_tx);
            rx_done    = (t == t_rx);
            force_poll = (t == t_fp);
            if (t == t_rx) rx_data = data;
            if (t == t_jl) jb_line = 1'b0;
            if (t == t_jh) jb_line = 1'b1;
        end
        at_cyc(last + 1);
        tx_done = 1'b0;
        rx_done = 1'b0;
        force_poll = 1'b0;
    endtask

    initial begin
        int x, s, c, kind, sel, e0, r;
        bit pend;

        at_cyc(3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_connected", 32'(connected), 32'd0);
        chk("rst_cntlr_data", cntlr_data, 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_rx_start", 32'(rx_start), 32'd0);
        chk("rst_cntlr_valid", 32'(cntlr_valid), 32'd0);
        chk("rst_timeout", 32'(timeout_pulse), 32'd0);
        chk("tx_cmd", {8'h00, tx_cmd}, {8'h00, CMD});
        rst_n = 1'b1;

        // periodic polling
        e0 = 10;
        at_cyc(e0);
        enable = 1'b1;
        for (int i = 1; i <= 3; i++) run_txn(e0 + P * i + 1, 0, 1'b1, 1'b0, x, pend);
        at_cyc(e0 + 4 * P - 10);
        enable = 1'b0;

        // forced polls with random responses, failures and retries
        pend = 1'b0;
        x = cyc - GAP - 2;
        for (int i = 0; i < 40; i++) begin
            if (pend) begin
                s = x + GAP + 2;
            end else begin
                c = ((cyc > x) ? cyc : x) + 1 + int'($urandom_range(0, 20));
                at_cyc(c);
                force_poll = 1'b1;
                if ($urandom_range(0, 1) == 1) begin
                    tx_done = 1'b1;
                    rx_done = 1'b1;
                    rx_data = $urandom();
                end
                at_cyc(c + 1);
                force_poll = 1'b0;
                tx_done = 1'b0;
                rx_done = 1'b0;
                s = (c + 2 > x + GAP + 2) ? c + 2 : x + GAP + 2;
            end
            sel = int'($urandom_range(0, 19));
            kind = (sel < 9) ? 0 : (sel < 12) ? 1 : (sel < 16) ? 2 : 3;
            run_txn(s, kind, 1'b0, 1'b1, x, pend);
        end
        while (pend) run_txn(x + GAP + 2, 0, 1'b0, 1'b0, x, pend);

        // reset in the middle of RECV
        c = ((cyc > x) ? cyc : x) + GAP + 4;
        at_cyc(c);
        force_poll = 1'b1;
        at_cyc(c + 1);
        force_poll = 1'b0;
        s = c + 2;
        r = s + 3;
        expect_ev(0, s, {8'h00, CMD}, m_conn);
        expect_ev(1, r, m_data, m_conn);
        at_cyc(s);
        tx_done = 1'b1;
        jb_line = 1'b0;
        at_cyc(s + 1);
        tx_done = 1'b0;
        at_cyc(r + 1);
        chk("busy_in_recv", 32'(busy), 32'd1);
        at_cyc(r + 2);
        rst_n = 1'b0;
        at_cyc(r + 3);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_connected", 32'(connected), 32'd0);
        chk("midrst_cntlr_data", cntlr_data, 32'd0);
        rst_n = 1'b1;
        m_conn = 1'b0;
        m_data = '0;
        rc = 0;
        at_cyc(r + 4);
        rx_done = 1'b1;
        rx_data = $urandom();
        jb_line = 1'b1;
        at_cyc(r + 5);
        rx_done = 1'b0;
        at_cyc(r + 30);
        chk("late_rx_busy", 32'(busy), 32'd0);
        chk("pending_events", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
